// File: rtl/operand2_ctrl_pkg.sv
// operand2_ctrl_pkg: barrel shifter mode codes and controller state encodings
package operand2_ctrl_pkg;
    typedef enum logic [3:0] {
        IMMED, LSLIMM, LSRIMM, ASRIMM, RORIMM, LSLREG, LSRREG, ASRREG, RORREG
    } bsel_t;
    typedef enum logic [2:0] {IDLE, RD_RM, RD_RS, CAP, SHIFT, DONE} state_t;
    localparam logic [3:0] R15 = 4'd15;
    function automatic logic [3:0] shift_sel(input logic by_reg, input logic [1:0] t);
        return (by_reg ? 4'(LSLREG) : 4'(LSLIMM)) + {2'b0, t};
    endfunction
endpackage

// File: rtl/operand2_ctrl.sv
// operand2_ctrl: sequences Rm/Rs reads over one register-file port and drives the
// external barrel shifter, latching its result as the ARM second operand
module operand2_ctrl
    import operand2_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        is_imm,
    input  logic        shift_by_reg,
    input  logic [1:0]  shift_type,
    input  logic [4:0]  imm_shift,
    input  logic [3:0]  rot_imm,
    input  logic [7:0]  imm8,
    input  logic [3:0]  rm,
    input  logic [3:0]  rs,
    input  logic        c_flag,
    input  logic [31:0] pc,
    output logic [3:0]  rf_addr,
    input  logic [31:0] rf_data,
    output logic [3:0]  barrel_sel,
    output logic [31:0] shiftee,
    output logic [31:0] shifter,
    output logic        bs_c_flag,
    input  logic [31:0] shifter_operand,
    input  logic        shifter_carry_out,
    output logic        busy,
    output logic        done,
    output logic [31:0] operand,
    output logic        carry_out
);
    state_t      r_state, w_next;
    logic        r_sbr, r_c;
    logic [1:0]  r_type;
    logic [4:0]  r_imm_shift;
    logic [3:0]  r_rm, r_rs, r_rf_addr, r_sel;
    logic [31:0] r_pc, r_rm_val, r_shiftee, r_shifter, r_operand;
    logic        r_bs_c, r_carry;
    logic [3:0]  w_cap_idx;
    logic [31:0] w_cap;

    // R15 is never read; the pipeline-visible PC value replaces the read data
    assign w_cap_idx = (r_state == CAP && r_sbr) ? r_rs : r_rm;
    assign w_cap     = (w_cap_idx == R15) ? r_pc + (r_sbr ? 32'd12 : 32'd8) : rf_data;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    w_next = start ? (is_imm ? SHIFT : RD_RM) : IDLE;
            RD_RM:   w_next = r_sbr ? RD_RS : CAP;
            RD_RS:   w_next = CAP;
            CAP:     w_next = SHIFT;
            SHIFT:   w_next = DONE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (r_state == IDLE && start) begin
            r_sbr       <= shift_by_reg;
            r_type      <= shift_type;
            r_imm_shift <= imm_shift;
            r_rm        <= rm;
            r_rs        <= rs;
            r_c         <= c_flag;
            r_pc        <= pc;
        end
        if (r_state == RD_RS) r_rm_val <= w_cap;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_rf_addr <= '0;
            r_sel     <= IMMED;
            r_shiftee <= '0;
            r_shifter <= '0;
            r_bs_c    <= 1'b0;
            r_operand <= '0;
            r_carry   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && start) begin
                if (is_imm) begin
                    r_sel     <= IMMED;
                    r_shiftee <= {24'b0, imm8};
                    r_shifter <= {27'b0, rot_imm, 1'b0};
                    r_bs_c    <= c_flag;
                end else if (rm != R15) begin
                    r_rf_addr <= rm;
                end
            end
            if (r_state == RD_RM && r_sbr && r_rs != R15) r_rf_addr <= r_rs;
            if (r_state == CAP) begin
                r_sel     <= shift_sel(r_sbr, r_type);
                r_shiftee <= r_sbr ? r_rm_val : w_cap;
                r_shifter <= r_sbr ? {24'b0, w_cap[7:0]} : {27'b0, r_imm_shift};
                r_bs_c    <= r_c;
            end
            if (r_state == SHIFT) begin
                r_operand <= shifter_operand;
                r_carry   <= shifter_carry_out;
            end
        end
    end

    assign rf_addr    = r_rf_addr;
    assign barrel_sel = r_sel;
    assign shiftee    = r_shiftee;
    assign shifter    = r_shifter;
    assign bs_c_flag  = r_bs_c;
    assign operand    = r_operand;
    assign carry_out  = r_carry;
    assign busy       = r_state != IDLE;
    assign done       = r_state == DONE;
endmodule
